// File: rtl/adc_ch_accum_pkg.sv
// adc_ch_accum_pkg
// Shared definitions for the per-channel ADC accumulator. The *_DEF constants
// are the system defaults. CH_NUM_DEF is also used by the ADG408 address
// sequencer, so the channel count is defined once for both blocks.
package adc_ch_accum_pkg;

    localparam int ADC_W_DEF      = 12;   // ADC sample width, unsigned
    localparam int SUM_SHIFT_DEF  = 4;    // log2 of samples per channel
    localparam int SETTLE_CYC_DEF = 32;   // cycles discarded after each mux switch
    localparam int CH_NUM_DEF     = 7;    // channels per sweep, 1..8

    // Width of a full channel sum. It is sized so that the worst case,
    // 2^SUM_SHIFT samples of full-scale data, cannot wrap.
    localparam int SUM_W = ADC_W_DEF + SUM_SHIFT_DEF;

    // Channel index width. It is fixed because the ADG408 has eight inputs.
    localparam int CH_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    // Returns the counter width needed to hold a settle load of 'cyc'.
    function automatic int settle_cnt_w(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/adc_settle_timer.sv
// adc_settle_timer
// Loadable down-counter. It counts while 'en' is high and asserts 'done'
// combinationally in the last counted cycle. Loading with N gives 'done' in
// the N-th enabled cycle after the load.
module adc_settle_timer
    import adc_ch_accum_pkg::*;
#(
    parameter int CNT_W = settle_cnt_w(SETTLE_CYC_DEF)
) (
    input  logic             clks,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Counter: a load wins over counting, and the count holds at zero.
    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // 'done' is suppressed while a load is pending so that a restart cannot
    // end the fresh interval early.
    assign done = en && !load && (cnt == CNT_W'(1));

endmodule

// File: rtl/adc_ch_accum.sv
// adc_ch_accum
// Per-channel ADC sample accumulator. This block sits upstream of the ADG408
// mux address sequencer. After each channel switch it discards SETTLE_CYC
// cycles. It then sums 2^SUM_SHIFT valid samples, publishes the result and
// pulses en_NT so the sequencer moves to the next channel. When the last of
// CH_NUM channels completes, it pulses all_done and returns to IDLE.
//
// Build option: define ADC_CH_ACCUM_AVG_EN to publish the channel mean
// (sum >> SUM_SHIFT, zero-extended) instead of the raw sum. Timing and
// handshake are identical in both builds.
module adc_ch_accum
    import adc_ch_accum_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int SUM_SHIFT  = SUM_SHIFT_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CH_NUM     = CH_NUM_DEF
) (
    input  logic                       clks,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADC_W-1:0]           adc_data,
    input  logic                       adc_valid,
    output logic                       en_NT,
    output logic [ADC_W+SUM_SHIFT-1:0] sum_out,
    output logic                       sum_valid,
    output logic [CH_W-1:0]            sum_ch,
    output logic                       all_done,
    output logic                       busy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int ACC_W  = ADC_W + SUM_SHIFT;
    localparam int SCNT_W = settle_cnt_w(SETTLE_CYC);
    // One extra bit keeps the counter legal even for a single-sample channel.
    localparam int SAMP_W = SUM_SHIFT + 1;

    localparam logic [SAMP_W-1:0] LAST_SAMP   = SAMP_W'((1 << SUM_SHIFT) - 1);
    localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(CH_NUM - 1);
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC);

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    state_t              state;
    state_t              next_state;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    sum_next;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [CH_W-1:0]     ch_cnt;

    logic                settle_done;
    logic                timer_load;
    logic                timer_en;
    logic                accept;
    logic                complete;
    logic                last_ch;

    // ------------------------------------------------------------------
    // Settle interval timer
    // ------------------------------------------------------------------
    // The timer is loaded on start and on every non-final completion, which
    // are the two moments a new channel begins. It counts only in SETTLE,
    // so the first sample can be accepted SETTLE_CYC + 1 cycles after the
    // load.
    adc_settle_timer #(
        .CNT_W (SCNT_W)
    ) u_settle_timer (
        .clks     (clks),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .en       (timer_en),
        .done     (settle_done)
    );

    // ------------------------------------------------------------------
    // Accumulator arithmetic
    // ------------------------------------------------------------------
    // The accumulator is wide enough for a full-scale channel, so a plain
    // add is used and no saturation is needed.
    assign acc_next = acc + ACC_W'(adc_data);

`ifdef ADC_CH_ACCUM_AVG_EN
    // The mean is the completed sum shifted down. The upper bits fill with
    // zeros, so the published value is zero-extended.
    assign sum_next = acc_next >> SUM_SHIFT;
`else
    assign sum_next = acc_next;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Sequential state update.
    always_ff @(posedge clks or negedge rst_n) begin
        // NOTE: clocked processes use non-blocking '<=' so every register
        // samples its inputs from before the edge, whatever the process
        // order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Next state. start restarts the sweep from any state and overrides a
    // completion in the same cycle.
    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // next_state, so no latch is inferred.
        next_state = state;
        if (start) begin
            next_state = SETTLE;
        end else begin
            unique case (state)
                IDLE:    next_state = IDLE;
                SETTLE:  if (settle_done) next_state = ACCUM;
                ACCUM:   if (complete)    next_state = last_ch ? IDLE : SETTLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    // Control strobes for the datapath and the timer, plus busy.
    always_comb begin
        accept     = 1'b0;
        complete   = 1'b0;
        last_ch    = 1'b0;
        timer_en   = 1'b0;
        timer_load = start;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            SETTLE: begin
                busy     = 1'b1;
                timer_en = 1'b1;
            end
            ACCUM: begin
                busy     = 1'b1;
                // A sample that arrives together with start is discarded,
                // because the channel it belongs to is being aborted.
                accept   = adc_valid && !start;
                complete = accept && (samp_cnt == LAST_SAMP);
                last_ch  = complete && (ch_cnt == LAST_CH);
                if (complete && !last_ch) begin
                    timer_load = 1'b1;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, sample counter, channel counter
    // ------------------------------------------------------------------
    // Accumulate accepted samples and clear everything on restart or at a
    // channel boundary.
    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            samp_cnt <= '0;
            ch_cnt   <= '0;
        end else if (start) begin
            acc      <= '0;
            samp_cnt <= '0;
            ch_cnt   <= '0;
        end else if (complete) begin
            acc      <= '0;
            samp_cnt <= '0;
            ch_cnt   <= last_ch ? '0 : ch_cnt + 1'b1;
        end else if (accept) begin
            acc      <= acc_next;
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers and handshake pulses
    // ------------------------------------------------------------------
    // Publish the channel result one cycle after its last sample. sum_out
    // and sum_ch hold until the next completion.
    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            en_NT     <= 1'b0;
            sum_valid <= 1'b0;
            all_done  <= 1'b0;
            sum_out   <= '0;
            sum_ch    <= '0;
        end else begin
            en_NT     <= complete;
            sum_valid <= complete;
            all_done  <= last_ch;
            if (complete) begin
                sum_out <= sum_next;
                sum_ch  <= ch_cnt;
            end
        end
    end

endmodule

// File: tb/tb_adc_ch_accum.sv
// tb_adc_ch_accum
// Directed scoreboard bench for adc_ch_accum with SUM_SHIFT=2, SETTLE_CYC=3
// and CH_NUM=7. Expected channel results are pushed when the completing
// sample is driven. A negedge monitor pops and compares them when the DUT
// reports a result. Compile with ADC_CH_ACCUM_AVG_EN to test the mean build.
module tb_adc_ch_accum;

    localparam int ADC_W      = 12;
    localparam int SUM_SHIFT  = 2;
    localparam int SETTLE_CYC = 3;
    localparam int CH_NUM     = 7;
    localparam int SUM_W      = ADC_W + SUM_SHIFT;

    logic             clks      = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic [ADC_W-1:0] adc_data  = '0;
    logic             adc_valid = 1'b0;
    logic             en_NT;
    logic [SUM_W-1:0] sum_out;
    logic             sum_valid;
    logic [2:0]       sum_ch;
    logic             all_done;
    logic             busy;

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [2:0]       ch;
        logic             last;
    } exp_t;

    exp_t sb[$];

    int passed    = 0;
    int total     = 0;
    int en_seen   = 0;
    int done_seen = 0;

    adc_ch_accum #(
        .ADC_W      (ADC_W),
        .SUM_SHIFT  (SUM_SHIFT),
        .SETTLE_CYC (SETTLE_CYC),
        .CH_NUM     (CH_NUM)
    ) dut (
        .clks      (clks),
        .rst_n     (rst_n),
        .start     (start),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .en_NT     (en_NT),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ch    (sum_ch),
        .all_done  (all_done),
        .busy      (busy)
    );

    always #5 clks = ~clks;

    // Reference value for a channel whose samples add up to 'raw'.
    function automatic logic [SUM_W-1:0] model(input int raw);
`ifdef ADC_CH_ACCUM_AVG_EN
        return SUM_W'(raw / (1 << SUM_SHIFT));
`else
        return SUM_W'(raw);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clks);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic settle_phase(input bit noise);
        for (int i = 0; i < SETTLE_CYC; i++) begin
            adc_valid = noise;
            adc_data  = ADC_W'(999);
            tick();
        end
        adc_valid = 1'b0;
    endtask

    // Drives one channel: the settle interval, then four samples. During
    // settle, adc_valid can carry 999 as noise that must be ignored.
    // Optional idle gaps can be placed between samples.
    task automatic run_channel(input int ch, input int s0, input int s1,
                               input int s2, input int s3,
                               input bit noise, input bit gaps, input bit last);
        int   s[4];
        int   raw;
        exp_t e;
        s   = '{s0, s1, s2, s3};
        raw = 0;
        settle_phase(noise);
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) begin
                adc_valid = 1'b0;
                adc_data  = ADC_W'(999);
                tick();
            end
            adc_valid = 1'b1;
            adc_data  = ADC_W'(s[i]);
            raw += s[i];
            if (i == 3) begin
                e.sum  = model(raw);
                e.ch   = 3'(ch);
                e.last = last;
                sb.push_back(e);
            end
            tick();
        end
        adc_valid = 1'b0;
        check("en_NT_at_T+1", en_NT, 1);
        check("all_done_at_T+1", all_done, last);
        check("busy_at_T+1", busy, !last);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the
    // active edge.
    always @(negedge clks) begin
        if (rst_n && (en_NT || sum_valid || all_done)) begin
            exp_t e;
            check("en_NT_eq_sum_valid", en_NT, sum_valid);
            if (en_NT)    en_seen++;
            if (all_done) done_seen++;
            if (sum_valid) begin
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sum_out", sum_out, e.sum);
                    check("sum_ch", sum_ch, e.ch);
                    check("all_done_with_result", all_done, e.last);
                end
            end else begin
                check("all_done_needs_sum_valid", sum_valid, 1);
            end
        end
    end

    initial begin
        int en0;
        int done0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clks);
        #1;
        check("rst_en_NT", en_NT, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_all_done", all_done, 0);
        check("rst_busy", busy, 0);
        check("rst_sum_out", sum_out, 0);
        check("rst_sum_ch", sum_ch, 0);
        rst_n = 1'b1;
        tick();

        // adc_valid while IDLE is ignored
        adc_valid = 1'b1;
        adc_data  = ADC_W'(500);
        repeat (3) tick();
        adc_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_no_en_NT", en_seen, 0);

        // Full sweep: masking, raw sum, full scale, gaps, zero, mixed values
        en0   = en_seen;
        done0 = done_seen;
        pulse_start();
        check("busy_after_start", busy, 1);
        run_channel(0, 100, 200, 300, 400, 1'b1, 1'b0, 1'b0);
        check("ch0_sum_direct", sum_out, model(1000));
        run_channel(1, 4095, 4095, 4095, 4095, 1'b0, 1'b0, 1'b0);
        check("full_scale_direct", sum_out, model(16380));
        run_channel(2, 1, 2, 3, 4, 1'b1, 1'b1, 1'b0);
        run_channel(3, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_channel(4, 4095, 0, 4095, 0, 1'b1, 1'b1, 1'b0);
        run_channel(5, 7, 11, 13, 17, 1'b0, 1'b0, 1'b0);
        run_channel(6, 1000, 2000, 3000, 4000, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        check("sweep_en_NT_count", en_seen - en0, CH_NUM);
        check("sweep_all_done_count", done_seen - done0, 1);
        check("sweep_busy_low", busy, 0);
        check("sum_out_held", sum_out, model(10000));

        // Restart after 2 samples in channel 3
        pulse_start();
        run_channel(0, 10, 20, 30, 40, 1'b0, 1'b0, 1'b0);
        run_channel(1, 50, 60, 70, 80, 1'b0, 1'b0, 1'b0);
        run_channel(2, 90, 100, 110, 120, 1'b0, 1'b0, 1'b0);
        settle_phase(1'b0);
        adc_valid = 1'b1;
        adc_data  = ADC_W'(3000);
        repeat (2) tick();
        adc_valid = 1'b0;
        tick();
        en0 = en_seen;
        pulse_start();
        check("restart_busy", busy, 1);
        check("restart_no_en_NT", en_NT, 0);
        run_channel(0, 100, 200, 300, 400, 1'b1, 1'b0, 1'b0);
        tick();
        check("restart_one_en_NT", en_seen - en0, 1);

        // start coincident with the completing sample wins
        settle_phase(1'b0);
        adc_valid = 1'b1;
        adc_data  = ADC_W'(5);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start     = 1'b0;
        adc_valid = 1'b0;
        check("start_priority_no_en_NT", en_NT, 0);
        check("start_priority_no_sum_valid", sum_valid, 0);
        check("start_priority_busy", busy, 1);
        run_channel(0, 300, 300, 300, 301, 1'b1, 1'b0, 1'b0);

        // Reset mid-ACCUM (channel 1 of this sweep)
        settle_phase(1'b0);
        adc_valid = 1'b1;
        adc_data  = ADC_W'(77);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_en_NT", en_NT, 0);
        check("mid_rst_sum_valid", sum_valid, 0);
        check("mid_rst_all_done", all_done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sum_out", sum_out, 0);
        check("mid_rst_sum_ch", sum_ch, 0);
        #2;
        rst_n = 1'b1;
        en0   = en_seen;
        adc_data = ADC_W'(50);
        repeat (10) tick();
        adc_valid = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);
        check("post_rst_no_en_NT", en_seen - en0, 0);

        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
